// File: rtl/led_blinker_mc.sv
// Multi-channel E1 status LED blinker: derives per-LED blink patterns from a prescaled
// phase counter and pushes changed patterns to a shift-register interface.
// Optional periodic refresh is compiled in with `define LED_REFRESH_EN.
module led_blinker_mc #(
    parameter int CHAN_N   = 2,
    parameter int DIV_LOG2 = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*CHAN_N-1:0]   led_state,
    input  logic                  en,
    output logic [2*CHAN_N-1:0]   sr_val,
    output logic                  sr_go,
    input  logic                  sr_rdy
);

    localparam int unsigned LED_N = 2 * CHAN_N;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_HOLD = 1'b1;

    logic                state;
    logic [DIV_LOG2-1:0] presc;
    logic [3:0]          phase;
    logic                tick;
    logic [LED_N-1:0]    pattern;
    logic [LED_N-1:0]    last_sent;
    logic                force_flag;
    logic                en_q;
    logic                en_rise;
    logic                refresh;
    logic                issue;

    assign tick    = &presc;
    assign en_rise = en & ~en_q;

`ifdef LED_REFRESH_EN
    assign refresh = tick && (phase == 4'hF);
`else
    assign refresh = 1'b0;
`endif

    always_comb begin
        pattern = '0;
        for (int unsigned k = 0; k < LED_N; k++) begin
            case (led_state[2*k +: 2])
                2'b00:   pattern[k] = 1'b0;
                2'b01:   pattern[k] = 1'b1;
                2'b10:   pattern[k] = ~phase[3];
                default: pattern[k] = ~phase[1];
            endcase
        end
    end

    // An en rising edge is folded into the current eligibility check so that
    // it does not cause a second, redundant transfer once consumed.
    assign issue = (state == S_IDLE) && en && sr_rdy &&
                   ((pattern != last_sent) || force_flag || en_rise);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            phase <= '0;
        end else begin
            presc <= presc + 1'b1;
            if (tick) begin
                phase <= phase + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            force_flag <= 1'b1;
        end else begin
            en_q <= en;
            // A new request raised in the same cycle as a transfer takes precedence.
            if (refresh || (en_rise && !issue)) begin
                force_flag <= 1'b1;
            end else if (issue) begin
                force_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sr_go     <= 1'b0;
            sr_val    <= '0;
            last_sent <= '0;
        end else begin
            sr_go <= issue;
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        state     <= S_HOLD;
                        sr_val    <= pattern;
                        last_sent <= pattern;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_blinker_mc.sv
// Directed self-checking bench for led_blinker_mc (CHAN_N=2, DIV_LOG2=4).
// The refresh scenario replaces the default one when LED_REFRESH_EN is defined.
module tb_led_blinker_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  led_state;
    logic        en;
    logic [3:0]  sr_val;
    logic        sr_go;
    logic        sr_rdy;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;
    int b2b    = 0;
    logic prev_go = 1'b0;

    led_blinker_mc #(.CHAN_N(2), .DIV_LOG2(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .led_state (led_state),
        .en        (en),
        .sr_val    (sr_val),
        .sr_go     (sr_go),
        .sr_rdy    (sr_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sr_go && prev_go) b2b <= b2b + 1;
        prev_go <= sr_go;
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Waits up to limit negedges for sr_go; reports its cycle and value.
    task automatic wait_go(input string tag, input int limit, output int at, output logic [3:0] v);
        bit ok = 0;
        at = -1;
        v  = '0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (sr_go === 1'b1) begin
                ok = 1;
                at = cyc;
                v  = sr_val;
            end
        end
        check({tag, "_seen"}, int'(ok), 1);
    endtask

    task automatic count_go(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sr_go === 1'b1) cnt++;
        end
    endtask

    int at_a, at_b, at_c, cnt, t0;
    logic [3:0] v_a, v_b, v_c, hold_val;

    initial begin
        rst_n     = 1'b0;
        led_state = 8'h00;
        en        = 1'b1;
        sr_rdy    = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_go", int'(sr_go), 0);
        check("rst_val", int'(sr_val), 0);

`ifndef LED_REFRESH_EN
        // First transfer right after reset, then silence with a static off pattern.
        rst_n = 1'b1;
        t0 = cyc;
        wait_go("first", 4, at_a, v_a);
        check("first_lat", at_a - t0, 1);
        check("first_val", int'(v_a), 0);
        count_go(256, cnt);
        check("static_quiet", cnt, 0);

        // All on.
        led_state = 8'h55;
        t0 = cyc;
        wait_go("all_on", 4, at_a, v_a);
        check("all_on_lat", at_a - t0, 1);
        check("all_on_val", int'(v_a), 4'hF);
        count_go(100, cnt);
        check("all_on_quiet", cnt, 0);

        // LED0 fast blink: one toggle every 32 cycles.
        led_state = 8'h03;
        wait_go("fast_a", 4, at_a, v_a);
        wait_go("fast_b", 40, at_b, v_b);
        wait_go("fast_c", 40, at_c, v_c);
        check("fast_period", at_c - at_b, 32);
        check("fast_toggle", int'(v_c), int'(v_b ^ 4'h1));
        check("fast_upper", int'(v_c[3:1]), 0);

        // Back-pressure: only the latest pattern goes out.
        @(negedge clk);
        sr_rdy    = 1'b0;
        led_state = 8'h01;
        hold_val  = sr_val;
        count_go(33, cnt);
        led_state = 8'h04;
        count_go(33, t0);
        cnt += t0;
        led_state = 8'h10;
        count_go(34, t0);
        cnt += t0;
        check("bp_quiet", cnt, 0);
        check("bp_stable", int'(sr_val), int'(hold_val));
        sr_rdy = 1'b1;
        t0 = cyc;
        wait_go("bp_go", 4, at_a, v_a);
        check("bp_lat", at_a - t0, 1);
        check("bp_val", int'(v_a), 4'h4);
        count_go(50, cnt);
        check("bp_single", cnt, 0);

        // en low blocks transfers; en rising gives exactly one.
        en = 1'b0;
        led_state = 8'h01;
        count_go(20, cnt);
        led_state = 8'h40;
        count_go(20, t0);
        cnt += t0;
        check("en_low_quiet", cnt, 0);
        en = 1'b1;
        t0 = cyc;
        wait_go("en_rise", 4, at_a, v_a);
        check("en_rise_lat", at_a - t0, 1);
        check("en_rise_val", int'(v_a), 4'h8);
        count_go(50, cnt);
        check("en_rise_single", cnt, 0);

        // Reset during HOLD aborts; first transfer after release repeats pattern.
        led_state = 8'h05;
        wait_go("pre_rst", 4, at_a, v_a);
        check("pre_rst_val", int'(v_a), 4'h3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_go", int'(sr_go), 0);
        check("mid_rst_val", int'(sr_val), 0);
        count_go(5, cnt);
        check("rst_quiet", cnt, 0);
        rst_n = 1'b1;
        t0 = cyc;
        wait_go("post_rst", 4, at_a, v_a);
        check("post_rst_lat", at_a - t0, 1);
        check("post_rst_val", int'(v_a), 4'h3);
`else
        // Static all-on pattern refreshed every 16 ticks (256 cycles).
        led_state = 8'h55;
        rst_n = 1'b1;
        t0 = cyc;
        wait_go("ref_first", 4, at_a, v_a);
        check("ref_first_lat", at_a - t0, 1);
        check("ref_first_val", int'(v_a), 4'hF);
        wait_go("ref_b", 300, at_b, v_b);
        wait_go("ref_c", 300, at_c, v_c);
        check("ref_period", at_c - at_b, 256);
        check("ref_val_b", int'(v_b), 4'hF);
        check("ref_val_c", int'(v_c), 4'hF);
        rst_n = 1'b0;
        #1;
        check("ref_rst_go", int'(sr_go), 0);
        check("ref_rst_val", int'(sr_val), 0);
        count_go(5, cnt);
        check("ref_rst_quiet", cnt, 0);
        rst_n = 1'b1;
        wait_go("ref_post", 4, at_a, v_a);
        check("ref_post_val", int'(v_a), 4'hF);
`endif

        repeat (2) @(negedge clk);
        check("no_back_to_back", b2b, 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
